// File: rtl/bp_update_arbiter.sv
// Serializes up to two branch-resolution requests per cycle onto the predictor's single update port.
// Define BP_UPDATE_COALESCE_EN to merge requests whose PC already waits in the queue.
`ifndef XLEN
`define XLEN 32
`endif

module bp_update_arbiter #(
  parameter int unsigned BP_UQ_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [1:0]                    req_valid,
  input  logic [1:0][`XLEN-1:0]         req_pc,
  input  logic [1:0]                    req_direction,
  input  logic [1:0][`XLEN-1:0]         req_target,
  output logic                          req_ready,
  input  logic                          flush,
  output logic                          update_EN,
  output logic [`XLEN-1:0]              update_pc,
  output logic                          update_direction,
  output logic [`XLEN-1:0]              update_target,
  output logic [$clog2(BP_UQ_DEPTH):0]  uq_count
);

  localparam int unsigned XW    = `XLEN;
  localparam int unsigned PTR_W = $clog2(BP_UQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XW-1:0] pc;
    logic          direction;
    logic [XW-1:0] target;
  } uq_entry_t;

  uq_entry_t        mem_q [BP_UQ_DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  uq_entry_t        lane_entry [2];
  uq_entry_t        head_entry;
  logic             pop;
  logic [1:0]       acc;
  logic             alloc0;
  logic             alloc1;
  logic [1:0]       n_alloc;
  logic [PTR_W-1:0] wr_idx0;
  logic [PTR_W-1:0] wr_idx1;

`ifdef BP_UPDATE_COALESCE_EN
  logic             hit0;
  logic             hit1;
  logic             same_pc;
  logic             live;
  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] hit0_idx;
  logic [PTR_W-1:0] hit1_idx;
`endif

  // Occupancy-derived status; the head is always consumed while the queue is non-empty.
  assign req_ready = (CNT_W'(BP_UQ_DEPTH) - count_q) >= CNT_W'(2);
  assign pop       = (count_q != '0);
  assign uq_count  = count_q;

  assign head_entry       = mem_q[head_q];
  assign update_EN        = pop;
  assign update_pc        = pop ? head_entry.pc        : '0;
  assign update_direction = pop ? head_entry.direction : 1'b0;
  assign update_target    = pop ? head_entry.target    : '0;

  always_comb begin
    lane_entry[0] = '{pc: req_pc[0], direction: req_direction[0], target: req_target[0]};
    lane_entry[1] = '{pc: req_pc[1], direction: req_direction[1], target: req_target[1]};
  end

  // Slot selection for the accepted lanes.
  always_comb begin
    acc     = req_valid & {2{req_ready & ~flush & ~reset}};
    alloc0  = 1'b0;
    alloc1  = 1'b0;
    wr_idx0 = tail_q;
    wr_idx1 = tail_q;
`ifdef BP_UPDATE_COALESCE_EN
    hit0     = 1'b0;
    hit1     = 1'b0;
    live     = 1'b0;
    idx      = head_q;
    hit0_idx = head_q;
    hit1_idx = head_q;
    same_pc  = acc[0] && (req_pc[0] == req_pc[1]);
    // The head leaves this cycle whenever it exists, so only offsets 1..count-1 can be merged into.
    for (int unsigned k = 1; k < BP_UQ_DEPTH; k++) begin
      idx  = head_q + PTR_W'(k);
      live = CNT_W'(k) < count_q;
      if (live && (mem_q[idx].pc == req_pc[0])) begin
        hit0     = 1'b1;
        hit0_idx = idx;
      end
      if (live && (mem_q[idx].pc == req_pc[1])) begin
        hit1     = 1'b1;
        hit1_idx = idx;
      end
    end
    alloc0  = acc[0] & ~hit0;
    wr_idx0 = hit0 ? hit0_idx : tail_q;
    if (hit1) begin
      wr_idx1 = hit1_idx;
    end else if (same_pc) begin
      wr_idx1 = wr_idx0;
    end else begin
      wr_idx1 = tail_q + PTR_W'(alloc0);
    end
    alloc1  = acc[1] & ~hit1 & ~same_pc;
`else
    alloc0  = acc[0];
    alloc1  = acc[1];
    wr_idx0 = tail_q;
    wr_idx1 = tail_q + PTR_W'(alloc0);
`endif
    n_alloc = 2'(alloc0) + 2'(alloc1);
  end

  // Lane 1 is written after lane 0 so it wins when both target the same slot.
  always_ff @(posedge clock) begin
    if (acc[0]) mem_q[wr_idx0] <= lane_entry[0];
    if (acc[1]) mem_q[wr_idx1] <= lane_entry[1];
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(pop);
      tail_q  <= tail_q + PTR_W'(n_alloc);
      count_q <= count_q + CNT_W'(n_alloc) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Bench for bp_update_arbiter: directed scenarios then random traffic against a queue reference model.
// Honors BP_UPDATE_COALESCE_EN the same way the design does.
`ifndef XLEN
`define XLEN 32
`endif

module tb_bp_update_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XW    = `XLEN;

  typedef struct packed {
    logic [XW-1:0] pc;
    logic          dir;
    logic [XW-1:0] tgt;
  } ent_t;

  logic                       clock = 1'b0;
  logic                       reset;
  logic [1:0]                 req_valid;
  logic [1:0][XW-1:0]         req_pc;
  logic [1:0]                 req_direction;
  logic [1:0][XW-1:0]         req_target;
  logic                       req_ready;
  logic                       flush;
  logic                       update_EN;
  logic [XW-1:0]              update_pc;
  logic                       update_direction;
  logic [XW-1:0]              update_target;
  logic [$clog2(DEPTH):0]     uq_count;

  int   checks = 0;
  int   errors = 0;
  ent_t model_q[$];
  int unsigned np;
  bit   hold_rdy;

  bp_update_arbiter #(.BP_UQ_DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_pc           (req_pc),
    .req_direction    (req_direction),
    .req_target       (req_target),
    .req_ready        (req_ready),
    .flush            (flush),
    .update_EN        (update_EN),
    .update_pc        (update_pc),
    .update_direction (update_direction),
    .update_target    (update_target),
    .uq_count         (uq_count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic ent_t mk(input int unsigned pc, input logic d, input int unsigned t);
    ent_t e;
    e.pc  = XW'(pc);
    e.dir = d;
    e.tgt = XW'(t);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    return (int'(DEPTH) - model_q.size()) >= 2;
  endfunction

  // A request with a PC already waiting behind the head overwrites it when coalescing.
  function automatic void model_push(input ent_t e);
`ifdef BP_UPDATE_COALESCE_EN
    foreach (model_q[i]) begin
      if (model_q[i].pc == e.pc) begin
        model_q[i] = e;
        return;
      end
    end
`endif
    model_q.push_back(e);
  endfunction

  task automatic check_outputs();
    ent_t h;
    bit   ne;
    h  = '0;
    ne = model_q.size() != 0;
    if (ne) h = model_q[0];
    check("update_EN",        64'(update_EN),        64'(ne));
    check("update_pc",        64'(update_pc),        64'(h.pc));
    check("update_direction", 64'(update_direction), 64'(h.dir));
    check("update_target",    64'(update_target),    64'(h.tgt));
    check("uq_count",         64'(uq_count),         64'(model_q.size()));
    check("req_ready",        64'(req_ready),        64'(model_ready()));
  endtask

  // One clock: check current outputs, drive inputs, advance the model, then step past the edge.
  task automatic step(input logic [1:0] v, input ent_t e0, input ent_t e1,
                      input logic fl, input logic rst);
    bit rdy;
    check_outputs();
    req_valid        = v;
    req_pc[0]        = e0.pc;
    req_pc[1]        = e1.pc;
    req_direction[0] = e0.dir;
    req_direction[1] = e1.dir;
    req_target[0]    = e0.tgt;
    req_target[1]    = e1.tgt;
    flush            = fl;
    reset            = rst;
    rdy              = model_ready();
    if (rst || fl) begin
      model_q.delete();
    end else begin
      if (model_q.size() != 0) void'(model_q.pop_front());
      if (rdy && v[0]) model_push(e0);
      if (rdy && v[1]) model_push(e1);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    req_valid     = '0;
    req_pc        = '0;
    req_direction = '0;
    req_target    = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_update_EN", 64'(update_EN), 64'd0);
    check("rst_update_pc", 64'(update_pc), 64'd0);
    check("rst_uq_count",  64'(uq_count),  64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);

    // Single push, one-cycle latency, queue drains.
    step(2'b01, mk(4, 1'b1, 80), '0, 1'b0, 1'b0);
    check("single_en",  64'(update_EN),        64'd1);
    check("single_pc",  64'(update_pc),        64'd4);
    check("single_dir", 64'(update_direction), 64'd1);
    check("single_tgt", 64'(update_target),    64'd80);
    idle(1);
    check("single_drain_en",  64'(update_EN), 64'd0);
    check("single_drain_cnt", 64'(uq_count),  64'd0);

    // Dual push emerges lane 0 then lane 1.
    step(2'b11, mk(8, 1'b0, 12), mk(16, 1'b1, 40), 1'b0, 1'b0);
    check("dual_first_pc", 64'(update_pc), 64'd8);
    idle(1);
    check("dual_second_pc",  64'(update_pc),     64'd16);
    check("dual_second_tgt", 64'(update_target), 64'd40);
    idle(2);

    // Requester holds both lanes until accepted; backpressure and pointer wrap.
    np = 256;
    for (int c = 0; c < 20; c++) begin
      hold_rdy = model_ready();
      step(2'b11, mk(np, np[3], np + 1000), mk(np + 4, ~np[3], np + 2000), 1'b0, 1'b0);
      if (hold_rdy) np += 8;
    end
    check("hold_full_ready", 64'(req_ready), 64'(uq_count < 3));
    idle(5);

    // Flush with three entries queued and both lanes requesting.
    step(2'b11, mk(40, 1'b1, 1), mk(44, 1'b0, 2), 1'b0, 1'b0);
    step(2'b11, mk(48, 1'b1, 3), mk(52, 1'b1, 4), 1'b0, 1'b0);
    check("pre_flush_cnt", 64'(uq_count), 64'd3);
    step(2'b11, mk(56, 1'b1, 5), mk(60, 1'b0, 6), 1'b1, 1'b0);
    check("flush_cnt", 64'(uq_count),  64'd0);
    check("flush_en",  64'(update_EN), 64'd0);
    idle(3);
    // Flush while ready: accepted-looking requests must still be dropped.
    step(2'b11, mk(64, 1'b1, 7), mk(68, 1'b0, 8), 1'b0, 1'b0);
    step(2'b11, mk(72, 1'b1, 9), mk(76, 1'b1, 10), 1'b1, 1'b0);
    check("flush_ready_cnt", 64'(uq_count), 64'd0);
    idle(2);

    // Same PC queued behind the head, then re-resolved.
    step(2'b11, mk(20, 1'b0, 1), mk(4, 1'b0, 20), 1'b0, 1'b0);
    step(2'b01, mk(4, 1'b1, 80), '0, 1'b0, 1'b0);
    check("dup_pc", 64'(update_pc), 64'd4);
`ifdef BP_UPDATE_COALESCE_EN
    check("dup_cnt", 64'(uq_count),         64'd1);
    check("dup_dir", 64'(update_direction), 64'd1);
    check("dup_tgt", 64'(update_target),    64'd80);
`else
    check("dup_cnt", 64'(uq_count),         64'd2);
    check("dup_dir", 64'(update_direction), 64'd0);
    check("dup_tgt", 64'(update_target),    64'd20);
`endif
    idle(3);
    // Both lanes share a PC in one cycle.
    step(2'b11, mk(36, 1'b0, 5), mk(36, 1'b1, 6), 1'b0, 1'b0);
    idle(3);

    // Reset with two entries queued and requests present.
    step(2'b11, mk(100, 1'b1, 11), mk(104, 1'b1, 12), 1'b0, 1'b0);
    step(2'b11, mk(108, 1'b1, 13), mk(112, 1'b0, 14), 1'b0, 1'b1);
    check("mid_rst_en",    64'(update_EN), 64'd0);
    check("mid_rst_pc",    64'(update_pc), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    idle(3);

    // Random traffic with a small PC pool so duplicates are common.
    for (int c = 0; c < 600; c++) begin
      step(2'($urandom_range(0, 3)),
           mk(4 * $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom),
           mk(4 * $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom),
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 49) == 0));
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_update_arbiter.md
BP_UPDATE_ARBITER -- requirements
Module: bp_update_arbiter

Interface
REQ-001 Parameter: BP_UQ_DEPTH, default 4, update-queue entries; power of two, >= 2.
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  [1:0]  branch-resolution request per lane; lane 0 older in program order.
REQ-005 req_pc  input  [1:0][`XLEN-1:0]  branch PC per lane.
REQ-006 req_direction  input  [1:0]  resolved taken (1) / not-taken (0) per lane.
REQ-007 req_target  input  [1:0][`XLEN-1:0]  resolved target per lane.
REQ-008 req_ready  output  1  both lanes may present requests this cycle.
REQ-009 flush  input  1  discard all queued and incoming updates.
REQ-010 update_EN  output  1  predictor update strobe.
REQ-011 update_pc  output  `XLEN  PC of the update.
REQ-012 update_direction  output  1  direction of the update.
REQ-013 update_target  output  `XLEN  target of the update.
REQ-014 uq_count  output  $clog2(BP_UQ_DEPTH)+1  current queue occupancy.

Function
REQ-015 Block SHALL serialize up to two resolution requests per cycle onto the predictor's single update port through a circular FIFO of BP_UQ_DEPTH entries {pc, direction, target}.
REQ-016 req_ready SHALL be 1 iff (BP_UQ_DEPTH - uq_count) >= 2, computed from registered count only; a same-cycle pop is not credited.
REQ-017 Lane i is accepted iff req_valid[i] && req_ready; unaccepted requests are not stored, and the requester holds them.
REQ-018 Both lanes accepted in one cycle SHALL be enqueued lane 0 first, then lane 1; a single accepted lane occupies the next slot.
REQ-019 update_EN SHALL equal (uq_count != 0); update_pc/direction/target SHALL show the head entry, and SHALL be 0 when the queue is empty.
REQ-020 The predictor always accepts, so the head SHALL be popped every cycle update_EN = 1.
REQ-021 Latency: request accepted in cycle N into an empty queue SHALL appear on update_EN in cycle N+1; there is no same-cycle bypass.
REQ-022 Simultaneous pop and push(es) SHALL update count by (pushes - 1); head/tail pointers wrap modulo BP_UQ_DEPTH.
REQ-023 The queue SHALL never overflow; because of REQ-016, a push never targets an occupied slot.
REQ-024 flush = 1 SHALL empty the queue at the next edge (count = 0, pointers = 0) and SHALL drop same-cycle requests; update_EN is still driven from current state during the flush cycle.
REQ-025 Entry order SHALL be preserved from acceptance to update output.

Reset
REQ-026 While reset = 1 at posedge, count, head and tail SHALL be cleared; reset overrides flush and requests.
REQ-027 After reset: update_EN = 0, update_pc = 0, update_direction = 0, update_target = 0, uq_count = 0, req_ready = 1.
REQ-028 Reset mid-operation SHALL discard all queued entries; nothing queued before reset SHALL appear on update_EN afterwards.

Configuration
REQ-029 Macro BP_UPDATE_COALESCE_EN SHALL select PC coalescing.
REQ-030 With BP_UPDATE_COALESCE_EN defined: an accepted request whose pc matches a valid queued entry, excluding the head popped this cycle, SHALL overwrite that entry's direction/target in place without allocating a slot. If both lanes carry the same pc, one entry holds lane 1's values. req_ready rules are unchanged.
REQ-031 Without BP_UPDATE_COALESCE_EN: every accepted request allocates its own slot, including duplicates.

Verification
REQ-032 After reset, push lane 0 {pc 4, dir 1, tgt 80} in cycle N -> update_EN = 1, update_pc = 4, dir 1, target 80 in cycle N+1 only; uq_count returns to 0.
REQ-033 Both lanes push {8, 0, 12} and {16, 1, 40} into an empty queue -> update outputs show pc 8 then pc 16 on consecutive cycles.
REQ-034 Hold both lanes valid with distinct PCs, BP_UQ_DEPTH = 4 -> req_ready falls when uq_count = 3; no entry is lost or reordered; pointers wrap cleanly over 10+ requests.
REQ-035 Queue holds 3 entries and flush is asserted with req_valid = 2'b11 -> next cycle uq_count = 0, update_EN = 0, and the flushed-cycle requests never appear.
REQ-036 Coalesce on: queue holds pc 4 (not head) {dir 0, tgt 20}, then push pc 4 {dir 1, tgt 80} -> uq_count unchanged and the entry emits dir 1, target 80. Coalesce off: same stimulus -> two pc 4 updates in order.
REQ-037 Reset asserted with 2 entries queued -> outputs are 0 and req_ready = 1 the next cycle, and no stale update_EN is seen.
